iq_phase_cordic: RTL and testbench
==================================

Name: iq_phase_cordic

Overview:
- Consumer end of the Hilbert-transformer I/Q interface. Takes each sin/cos sample pair with its tick strobe.
- Computes instantaneous phase atan2(sin, cos) and unscaled magnitude with an iterative CORDIC in vectoring mode.
- Emits results with a one-cycle done pulse. Sits between the Hilbert transformer and the downstream phase-unwrap / OPD logic.

Parameters:
- NUM_BITS, 24, width of signed sin_i/cos_i.
- PHASE_BITS, 24, width of signed binary-angle phase_o (full scale ±pi).
- NUM_ITER, 16, CORDIC micro-rotations per sample (legal range 8..PHASE_BITS-2).

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- tick_i  input  1  one-cycle strobe: sin_i/cos_i valid this cycle.
- sin_i  input  NUM_BITS  signed quadrature component (Q).
- cos_i  input  NUM_BITS  signed in-phase component (I).
- phase_o  output  PHASE_BITS  signed binary angle, 2^(PHASE_BITS-1) LSB = pi.
- magnitude_o  output  NUM_BITS+1  unsigned sqrt(sin²+cos²)·K, with K≈1.64676 (CORDIC gain not removed).
- done_o  output  1  one-cycle pulse: phase_o/magnitude_o updated.
- overrun_o  output  1  one-cycle pulse: tick_i arrived while busy and was dropped.

Behaviour:
- Interface fixed: one clock clk_i; reset_i synchronous, active-high.
- Reset: phase_o=0, magnitude_o=0, done_o=0, overrun_o=0, FSM→IDLE, iteration counter=0. A reset mid-computation aborts it; no done_o follows.
- FSM states: IDLE, ROTATE.
- IDLE + tick_i:
  - Sign-extend inputs to NUM_BITS+2 bits (x=cos, y=sin).
  - Pre-rotate: if x<0 then x=-x, y=-y, z=2^(PHASE_BITS-1) (the ±pi pattern); else z=0.
  - Latch a zero flag if sin_i==0 and cos_i==0.
  - Go to ROTATE with iter=0.
- ROTATE, each cycle:
  - If y>=0: x+=y>>>iter, y-=x>>>iter, z+=ATAN[iter].
  - Else: x-=y>>>iter, y+=x>>>iter, z-=ATAN[iter].
  - All updates use pre-update values. Shifts are arithmetic. z wraps modulo 2^PHASE_BITS, i.e. modulo 2pi.
  - When iter==NUM_ITER-1: register phase_o=z and magnitude_o=x[NUM_BITS:0], set done_o for the next cycle, go to IDLE.
  - If the zero flag is set, register phase_o=0 and magnitude_o=0 instead, with the same latency.
- Latency: tick sampled at cycle T → done_o high at T+NUM_ITER+1, with outputs valid the same cycle. Outputs hold until the next done.
- Throughput: FSM is in IDLE during the done_o cycle, so a tick there is accepted. Minimum tick spacing is NUM_ITER+1 cycles.
- tick_i while in ROTATE: sample dropped, overrun_o=1 for one cycle, computation in flight unaffected.
- Width rules:
  - The 2 guard bits absorb negation of -2^(NUM_BITS-1) and gain growth: worst case |x| ≈ 2.33·2^(NUM_BITS-1), which fits.
  - x is non-negative after pre-rotation, so magnitude_o is x truncated to its low NUM_BITS+1 bits.
- ATAN[i] = round(atan(2^-i)/pi · 2^(PHASE_BITS-1)).
- Accuracy: |phase error| ≤ 128 LSB for defaults. Magnitude error ≤ 0.1 % of K·|v|.
- Exactly +pi cannot be represented; results at ±pi are reported as -2^(PHASE_BITS-1) or the nearest positive value within tolerance.

Decomposition:
- Package iq_phase_pkg:
  - state enum (IDLE, ROTATE);
  - PI_BINANG constant;
  - CORDIC gain constant for testbench use;
  - function returning ATAN[i] for a given PHASE_BITS, evaluated at elaboration.
- Sub-module cordic_vector_stage: combinational single micro-rotation (x, y, z, iter, atan in → x, y, z out), instantiated once and reused across iterations.

Test Plan:
- Reset mid-ROTATE (cos=1000000 ticked, reset 5 cycles later) → no done_o; outputs 0; next tick behaves normally.
- cos=1000000, sin=0 → done_o at T+17; phase_o=0±128; magnitude_o=1646760±1700.
- cos=0, sin=1000000 → phase_o=4194304±128. cos=0, sin=-1000000 → phase_o=-4194304±128.
- cos=-1000000, sin=±1 and cos=sin=-8388608 → phase_o near ±8388608 within 128, no overflow; second case gives phase_o=-6291456±128 and magnitude_o≈19535000±0.1 %.
- sin=cos=0 → phase_o=0, magnitude_o=0, done_o at T+17.
- Back-to-back: ticks every 17 cycles for 1000 random samples → every tick yields done_o, results match atan2 model. Ticks every 10 cycles → overrun_o on every second tick; dropped samples produce no done_o.

Source files
------------

// File: rtl/iq_phase_pkg.sv
// iq_phase_pkg: shared FSM type, angle constants and arctangent table for the I/Q phase CORDIC
package iq_phase_pkg;
  typedef enum logic {IDLE, ROTATE} state_t;
  localparam int PHASE_BITS_DEFAULT = 24;
  localparam longint PI_BINANG = longint'(1) << (PHASE_BITS_DEFAULT - 1);
  localparam real CORDIC_GAIN = 1.6467602581;
  function automatic logic [31:0] atan_lsb(input int i, input int pb);
    longint t;
    case (i)
      0: t = 536870912;
      1: t = 316933406;
      2: t = 167458907;
      3: t = 85004756;
      4: t = 42667331;
      5: t = 21354465;
      6: t = 10679838;
      7: t = 5340245;
      8: t = 2670163;
      9: t = 1335087;
      10: t = 667544;
      11: t = 333772;
      12: t = 166886;
      13: t = 83443;
      14: t = 41722;
      15: t = 20861;
      16: t = 10430;
      17: t = 5215;
      18: t = 2608;
      19: t = 1304;
      20: t = 652;
      21: t = 326;
      22: t = 163;
      23: t = 81;
      24: t = 41;
      25: t = 20;
      26: t = 10;
      27: t = 5;
      28: t = 3;
      29: t = 1;
      default: t = 0;
    endcase
    return pb >= 32 ? t[31:0] : 32'((t + (longint'(1) << (31 - pb))) >> (32 - pb));
  endfunction
endpackage

// File: rtl/cordic_vector_stage.sv
// cordic_vector_stage: one combinational vectoring-mode CORDIC micro-rotation
module cordic_vector_stage #(
  parameter int XW = 26,
  parameter int PB = 24,
  parameter int IW = 4
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic [PB-1:0] z,
  input  logic [PB-1:0] atan,
  input  logic [IW-1:0] iter,
  output logic signed [XW-1:0] x_next,
  output logic signed [XW-1:0] y_next,
  output logic [PB-1:0] z_next
);
  logic signed [XW-1:0] xs, ys;
  always_comb begin
    xs = x >>> iter;
    ys = y >>> iter;
    x_next = y[XW-1] ? x - ys : x + ys;
    y_next = y[XW-1] ? y + xs : y - xs;
    z_next = y[XW-1] ? z - atan : z + atan;
  end
endmodule

// File: rtl/iq_phase_cordic.sv
// iq_phase_cordic: iterative vectoring CORDIC giving phase and unscaled magnitude of each I/Q sample
module iq_phase_cordic import iq_phase_pkg::*; #(
  parameter int NUM_BITS = 24,
  parameter int PHASE_BITS = 24,
  parameter int NUM_ITER = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic signed [NUM_BITS-1:0] sin_i,
  input  logic signed [NUM_BITS-1:0] cos_i,
  output logic signed [PHASE_BITS-1:0] phase_o,
  output logic [NUM_BITS:0] magnitude_o,
  output logic done_o,
  output logic overrun_o
);
  localparam int XW = NUM_BITS + 2;
  localparam int IW = $clog2(NUM_ITER);
  localparam logic [PHASE_BITS-1:0] PI_Z = {1'b1, {(PHASE_BITS-1){1'b0}}};
  state_t state, state_next;
  logic signed [XW-1:0] x, y, x_next, y_next, x_in, y_in;
  logic [PHASE_BITS-1:0] z, z_next;
  logic [PHASE_BITS-1:0] atan_rom [NUM_ITER];
  logic [IW-1:0] iter;
  logic zero, last;
  for (genvar i = 0; i < NUM_ITER; i++) begin : g_atan
    assign atan_rom[i] = PHASE_BITS'(atan_lsb(i, PHASE_BITS));
  end
  assign x_in = XW'(cos_i);
  assign y_in = XW'(sin_i);
  assign last = iter == IW'(NUM_ITER - 1);
  cordic_vector_stage #(.XW(XW), .PB(PHASE_BITS), .IW(IW)) u_stage (
    .x(x), .y(y), .z(z), .atan(atan_rom[iter]), .iter(iter),
    .x_next(x_next), .y_next(y_next), .z_next(z_next)
  );
  always_comb begin
    state_next = state == IDLE ? (tick_i ? ROTATE : IDLE) : (last ? IDLE : ROTATE);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x <= '0;
      y <= '0;
      z <= '0;
      iter <= '0;
      zero <= 1'b0;
      phase_o <= '0;
      magnitude_o <= '0;
      done_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      done_o <= state == ROTATE && last;
      overrun_o <= state == ROTATE && tick_i;
      if (state == IDLE && tick_i) begin
        x <= x_in[XW-1] ? -x_in : x_in;
        y <= x_in[XW-1] ? -y_in : y_in;
        z <= x_in[XW-1] ? PI_Z : '0;
        zero <= cos_i == '0 && sin_i == '0;
        iter <= '0;
      end else if (state == ROTATE) begin
        x <= x_next;
        y <= y_next;
        z <= z_next;
        iter <= last ? '0 : iter + 1'b1;
        if (last) begin
          phase_o <= zero ? '0 : z_next;
          magnitude_o <= zero ? '0 : x_next[NUM_BITS:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_iq_phase_cordic.sv
// tb_iq_phase_cordic: scoreboard bench for the I/Q phase CORDIC with directed and random vectors
module tb_iq_phase_cordic;
  import iq_phase_pkg::*;
  typedef struct {
    int ph;
    int ph_tol;
    int mag;
    int mag_tol;
    longint cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset_i, tick_i, done_o, overrun_o;
  logic signed [23:0] sin_i, cos_i, phase_o;
  logic [24:0] magnitude_o;
  longint cyc = 0;
  int errors = 0, checks = 0;
  exp_t sb[$];
  iq_phase_cordic dut (
    .clk_i(clk), .reset_i(reset_i), .tick_i(tick_i), .sin_i(sin_i), .cos_i(cos_i),
    .phase_o(phase_o), .magnitude_o(magnitude_o), .done_o(done_o), .overrun_o(overrun_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", n, act, req, cyc);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic exp_t mk(input int ph, input int ptol, input int mag, input int mtol);
    exp_t e;
    e.ph = ph;
    e.ph_tol = ptol;
    e.mag = mag;
    e.mag_tol = mtol;
    e.cyc = 0;
    return e;
  endfunction
  function automatic exp_t model(input int c, input int s);
    real a, m;
    a = $atan2(real'(s), real'(c));
    m = $sqrt(real'(c) * real'(c) + real'(s) * real'(s)) * CORDIC_GAIN;
    if (c == 0 && s == 0) return mk(0, 0, 0, 0);
    return mk(int'(a / 3.14159265358979 * real'(PI_BINANG)), 128, int'(m), int'(m / 1000.0) + 8);
  endfunction
  task automatic tx(input int c, input int s, input bit ovr, input exp_t e, input int gap);
    cos_i = 24'(c);
    sin_i = 24'(s);
    tick_i = 1'b1;
    if (!ovr) begin
      e.cyc = cyc + 17;
      sb.push_back(e);
    end
    idle(1);
    tick_i = 1'b0;
    chk("overrun", overrun_o == ovr, longint'(overrun_o), longint'(ovr));
    idle(gap - 1);
  endtask
  exp_t me;
  logic signed [23:0] d;
  int ad, md;
  always @(posedge clk) begin
    #1;
    if (done_o) begin
      if (sb.size() == 0) chk("unexpected_done", 1'b0, 1, 0);
      else begin
        me = sb.pop_front();
        d = phase_o - 24'(me.ph);
        ad = d < 0 ? -int'(d) : int'(d);
        md = int'(magnitude_o) - me.mag;
        md = md < 0 ? -md : md;
        chk("latency", cyc == me.cyc, cyc, me.cyc);
        chk("phase", ad <= me.ph_tol, longint'(phase_o), me.ph);
        chk("magnitude", md <= me.mag_tol, longint'(magnitude_o), me.mag);
      end
    end
  end
  initial begin
    int c, s;
    reset_i = 1'b1;
    tick_i = 1'b0;
    sin_i = '0;
    cos_i = '0;
    idle(3);
    chk("reset_phase", phase_o == 0, longint'(phase_o), 0);
    chk("reset_mag", magnitude_o == 0, longint'(magnitude_o), 0);
    chk("reset_done", done_o == 0, longint'(done_o), 0);
    chk("reset_overrun", overrun_o == 0, longint'(overrun_o), 0);
    reset_i = 1'b0;
    idle(2);
    tx(1000000, 0, 1'b0, mk(0, 128, 1646760, 1700), 17);
    tx(0, 1000000, 1'b0, mk(4194304, 128, 1646760, 1700), 17);
    tx(0, -1000000, 1'b0, mk(-4194304, 128, 1646760, 1700), 17);
    tx(-1000000, 1, 1'b0, mk(8388605, 128, 1646760, 1700), 17);
    tx(-1000000, -1, 1'b0, mk(-8388605, 128, 1646760, 1700), 17);
    tx(-8388608, -8388608, 1'b0, mk(-6291456, 128, 19535983, 19536), 17);
    cos_i = 24'(1000000);
    sin_i = '0;
    tick_i = 1'b1;
    idle(1);
    tick_i = 1'b0;
    idle(4);
    reset_i = 1'b1;
    idle(1);
    reset_i = 1'b0;
    chk("midreset_phase", phase_o == 0, longint'(phase_o), 0);
    chk("midreset_mag", magnitude_o == 0, longint'(magnitude_o), 0);
    idle(20);
    tx(1000000, 0, 1'b0, mk(0, 128, 1646760, 1700), 17);
    tx(0, 0, 1'b0, mk(0, 0, 0, 0), 17);
    for (int k = 0; k < 1000; k++) begin
      do begin
        c = int'($urandom_range(16777215, 0)) - 8388608;
        s = int'($urandom_range(16777215, 0)) - 8388608;
      end while ((c < 0 ? -c : c) + (s < 0 ? -s : s) < (1 << 20));
      tx(c, s, 1'b0, model(c, s), 17);
    end
    for (int k = 0; k < 20; k++) begin
      c = int'($urandom_range(16777215, 0)) - 8388608;
      s = 3000000 - k * 300000;
      tx(c, s, k[0], model(c, s), 10);
    end
    for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
    chk("drain", sb.size() == 0, longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
